// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_subtractor_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter wide enough to hold WIDTH-1 without wrapping, including WIDTH=1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor_df.sv
// Dataflow 1-bit full subtractor: computes A - B - C.
module full_subtractor_df (
    output logic difference,
    output logic borrow,
    input  logic A,
    input  logic B,
    input  logic C
);

    assign difference = A ^ B ^ C;
    assign borrow     = (~A & (B | C)) | (B & C);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor_df cell, LSB first,
// borrow recirculated through a register, start/busy/done handshake.
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] d_shift;

    full_subtractor_df u_cell (
        .difference (cell_diff),
        .borrow     (cell_borrow),
        .A          (a_sr_q[0]),
        .B          (b_sr_q[0]),
        .C          (borrow_q)
    );

    // New result bit enters at the MSB; shifting works for WIDTH=1 too.
    assign d_shift = (d_sr_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));

    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        d_sr_d       = d_sr_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    d_sr_d   = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                d_sr_d   = d_shift;
                borrow_d = cell_borrow;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d       = d_shift;
                    borrow_out_d = cell_borrow;
                    state_d      = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            d_sr_q       <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            d_sr_q       <= d_sr_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule
